sync_fifo_v2: RTL and testbench

Parametrised successor to the current 32x32 synchronous FIFO. Same push/pop data path, plus:
- occupancy count;
- programmable almost-full / almost-empty thresholds;
- selectable standard or first-word-fall-through (FWFT) read mode;
- sticky overflow/underflow error flags.

It sits between the stimulus driver and the slave consumer. Its status outputs feed the monitor and the assertion/coverage layer.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_ram.sv | 57 +++++
 rtl/sync_fifo_v2.sv | 131 +++++++++++++
 tb/tb_sync_fifo_v2.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the sync_fifo_v2 family: read-mode enum,
// pointer-width helper and the status bundle consumed by monitor/coverage.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one read port that is either
// registered (standard mode) or asynchronous (fall-through mode).
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int         WIDTH = 32,
  parameter int         DEPTH = 32,
  parameter fifo_mode_e MODE  = FIFO_STD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  generate
    if (MODE == FIFO_FWFT) begin : g_async_rd
      logic unused_ok;
      assign unused_ok = &{1'b0, rst, re};
      assign rdata     = mem[raddr];
    end else begin : g_reg_rd
      logic [WIDTH-1:0] rdata_q;
      logic [WIDTH-1:0] rdata_d;

      // Output holds the last popped word until the next pop.
      always_comb begin
        rdata_d = rdata_q;
        if (re) begin
          rdata_d = mem[raddr];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q <= '0;
        end else begin
          rdata_q <= rdata_d;
        end
      end

      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_v2.sv
// Parametrised synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, FWFT option and sticky error flags.
module sync_fifo_v2
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int AF_THRESH  = FIFO_DEPTH - 4,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [FIFO_WIDTH-1:0]       data_in,
  input  logic                        rd_en,
  input  logic                        clr_err,
  output logic [FIFO_WIDTH-1:0]       data_out,
  output logic                        data_valid,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_empty,
  output logic                        almost_full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int         PW   = ptr_w(FIFO_DEPTH);
  localparam int         CW   = PW + 1;
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  localparam fifo_status_t STATUS_RST = '{
    empty:        1'b1,
    full:         1'b0,
    almost_empty: 1'b1,
    almost_full:  1'b0,
    overflow:     1'b0,
    underflow:    1'b0
  };

  generate
    if (!(AE_THRESH > 0 && AE_THRESH < AF_THRESH && AF_THRESH < FIFO_DEPTH)) begin : g_bad_thresh
      $error("sync_fifo_v2: need 0 < AE_THRESH < AF_THRESH < FIFO_DEPTH");
    end
    if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("sync_fifo_v2: FIFO_DEPTH must be a power of two >= 4");
    end
  endgenerate

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  fifo_status_t   status_q, status_d;
  logic           data_valid_q, data_valid_d;
  logic           wr_ok, rd_ok;
  logic [FIFO_WIDTH-1:0] ram_rdata;

  // A push into a full FIFO is accepted when a pop frees a slot on the same edge.
  always_comb begin
    wr_ok    = wr_en & (~status_q.full | rd_en);
    rd_ok    = rd_en & ~status_q.empty;
    wr_ptr_d = wr_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);

    status_d              = status_q;
    status_d.empty        = (count_d == '0);
    status_d.full         = (count_d == DEPTH_C);
    status_d.almost_empty = (count_d <= AE_C);
    status_d.almost_full  = (count_d >= AF_C);
    status_d.overflow     = (wr_en & ~wr_ok) | (status_q.overflow & ~clr_err);
    status_d.underflow    = (rd_en & ~rd_ok) | (status_q.underflow & ~clr_err);

    data_valid_d = (MODE == FIFO_FWFT) ? ~status_d.empty : rd_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      status_q     <= STATUS_RST;
      data_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      status_q     <= status_d;
      data_valid_q <= data_valid_d;
    end
  end

  fifo_ram #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .MODE  (MODE)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok & ~rst),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (rd_ok & ~rst),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  generate
    if (MODE == FIFO_FWFT) begin : g_out_fwft
      // Stale array contents are masked so data_out reads zero while empty.
      assign data_out = status_q.empty ? '0 : ram_rdata;
    end else begin : g_out_std
      assign data_out = ram_rdata;
    end
  endgenerate

  assign data_valid   = data_valid_q;
  assign count        = count_q;
  assign empty        = status_q.empty;
  assign full         = status_q.full;
  assign almost_empty = status_q.almost_empty;
  assign almost_full  = status_q.almost_full;
  assign overflow     = status_q.overflow;
  assign underflow    = status_q.underflow;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Drives one standard-mode and one FWFT-mode FIFO with identical stimulus and
// compares both against a queue-based reference model every cycle.
module tb_sync_fifo_v2;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AF = 28;
  localparam int AE = 4;
  localparam int CW = $clog2(D) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, wr_en, rd_en, clr_err;
  logic [W-1:0] data_in;

  logic [W-1:0]  s_dout, f_dout;
  logic          s_dv, s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
  logic          f_dv, f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
  logic [CW-1:0] s_count, f_count;

  sync_fifo_v2 #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .clr_err(clr_err),
    .data_out(s_dout), .data_valid(s_dv), .empty(s_empty), .full(s_full),
    .almost_empty(s_ae), .almost_full(s_af), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_v2 #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .clr_err(clr_err),
    .data_out(f_dout), .data_valid(f_dv), .empty(f_empty), .full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  // Reference model: the queue holds the FIFO contents, head at index 0.
  logic [W-1:0] q[$];
  bit           m_ovf, m_unf, m_sv;
  logic [W-1:0] m_sout;
  int           n_vec = 0;
  int           n_err = 0;
  int           n_txn = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (txn %0d)", tag, obs, exp, n_txn);
    end
  endtask

  task automatic check_all();
    int           n;
    logic [W-1:0] head;
    n    = q.size();
    head = (n != 0) ? q[0] : '0;
    check("s_count", s_count, n);
    check("s_empty", s_empty, n == 0);
    check("s_full",  s_full,  n == D);
    check("s_ae",    s_ae,    n <= AE);
    check("s_af",    s_af,    n >= AF);
    check("s_ovf",   s_ovf,   m_ovf);
    check("s_unf",   s_unf,   m_unf);
    check("s_dv",    s_dv,    m_sv);
    check("s_dout",  s_dout,  m_sout);
    check("f_count", f_count, n);
    check("f_empty", f_empty, n == 0);
    check("f_full",  f_full,  n == D);
    check("f_ae",    f_ae,    n <= AE);
    check("f_af",    f_af,    n >= AF);
    check("f_ovf",   f_ovf,   m_ovf);
    check("f_unf",   f_unf,   m_unf);
    check("f_dv",    f_dv,    n != 0);
    check("f_dout",  f_dout,  head);
  endtask

  task automatic step(input bit r, input bit w, input logic [W-1:0] d, input bit rd, input bit c);
    bit was_full, was_empty, do_wr, do_rd;
    rst = r; wr_en = w; data_in = d; rd_en = rd; clr_err = c;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf  = 0;
      m_unf  = 0;
      m_sv   = 0;
      m_sout = '0;
    end else begin
      was_full  = (q.size() == D);
      was_empty = (q.size() == 0);
      do_rd     = rd && !was_empty;
      do_wr     = w && (!was_full || rd);
      m_sv      = do_rd;
      if (do_rd) m_sout = q.pop_front();
      if (do_wr) q.push_back(d);
      m_ovf = (w && !do_wr) || (m_ovf && !c);
      m_unf = (rd && !do_rd) || (m_unf && !c);
    end
    #1;
    n_txn++;
    $display("txn %0d rst=%0b wr=%0b din=%0h rd=%0b clr=%0b -> count=%0d s_out=%0h f_out=%0h",
             n_txn, r, w, d, rd, c, s_count, s_dout, f_dout);
    check_all();
  endtask

  initial begin
    int max_cnt;
    int pw, pr;
    bit w, rd;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = '0;
    m_ovf = 0; m_unf = 0; m_sv = 0; m_sout = '0;

    // Reset and idle
    step(1, 0, 0, 0, 0);
    step(1, 1, 32'h1234, 1, 0);
    step(0, 0, 0, 0, 0);

    // Fill 0..31, then an extra write that must be dropped
    for (int i = 0; i < D; i++) step(0, 1, W'(i), 0, 0);
    step(0, 1, 32'hDEAD, 0, 0);
    check("drop_ovf", s_ovf, 1);
    check("drop_cnt", s_count, D);

    // Push and pop together while full
    step(0, 1, 32'h100, 1, 0);
    check("full_both_pop", s_dout, 0);
    check("full_both_cnt", s_count, D);

    // Drain; the last word out is the one pushed while full
    for (int i = 0; i < D; i++) step(0, 0, 0, 1, 0);
    check("drain_last", s_dout, 32'h100);
    check("drain_unf", s_unf, 0);

    // Push and pop together while empty
    step(0, 1, 32'h55, 1, 0);
    check("empty_both_unf", s_unf, 1);
    check("empty_both_cnt", s_count, 1);
    step(0, 0, 0, 0, 1);
    check("clr_ovf", s_ovf, 0);
    check("clr_unf", s_unf, 0);

    // Fall-through: write to empty shows up without a read
    step(0, 0, 0, 1, 0);
    step(0, 1, 32'hA5, 0, 0);
    check("fwft_head", f_dout, 32'hA5);
    check("fwft_dv", f_dv, 1);
    step(0, 0, 0, 1, 0);
    check("fwft_empty", f_empty, 1);

    // Overflow in the same cycle as clr_err keeps the flag set
    for (int i = 0; i < D; i++) step(0, 1, $urandom, 0, 0);
    step(0, 1, 32'hBEEF, 0, 1);
    check("clr_vs_ovf", s_ovf, 1);

    // Reset mid-stream at count 10
    for (int i = 0; i < D - 10; i++) step(0, 0, 0, 1, 0);
    check("pre_rst_cnt", s_count, 10);
    step(1, 0, 0, 0, 0);
    check("rst_cnt", s_count, 0);
    check("rst_dv", s_dv, 0);
    step(0, 0, 0, 0, 0);

    // Interleaved traffic around count 16 across pointer wrap
    for (int i = 0; i < 16; i++) step(0, 1, $urandom, 0, 0);
    max_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      w  = ($urandom_range(1) == 1) && (s_count < 17);
      rd = ($urandom_range(1) == 1) || (s_count >= 17);
      step(0, w, $urandom, rd, 0);
      if (int'(s_count) > max_cnt) max_cnt = int'(s_count);
    end
    check("wrap_max_le17", max_cnt <= 17, 1);

    // Random traffic with varying bias, occasional clears and resets
    for (int blk = 0; blk < 15; blk++) begin
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++) begin
        step(($urandom_range(299) == 0),
             ($urandom_range(99) < pw), $urandom,
             ($urandom_range(99) < pr),
             ($urandom_range(15) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
